// File: rtl/dmem_pkg.sv
// Shared types and lane-mask helpers for the byte-enabled data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_e;

  // Lane enable bit k covers word bits [8k+7:8k]; byte offset 0 is lane 3.
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;

  // Lane enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      MEM_BYTE: m = BE_BYTE << (2'd3 - off);
      MEM_HALF: m = off[1] ? BE_HALF : (BE_HALF << 2);
      MEM_WORD: m = 4'b1111;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Selects the addressed byte/halfword/word from a big-endian memory word and extends it.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword lanes.
  always_comb begin
    byte_sel = 8'h00;
    case (offset_i)
      2'd0: byte_sel = word_i[31:24];
      2'd1: byte_sel = word_i[23:16];
      2'd2: byte_sel = word_i[15:8];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = offset_i[1] ? word_i[15:0] : word_i[31:16];
  end

  // Extend to 32 bits; words pass through regardless of the unsigned flag.
  always_comb begin
    data_o = 32'h0;
    case (size_i)
      MEM_BYTE: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      MEM_HALF: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      MEM_WORD: data_o = word_i;
      default:  data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_memory_be.sv
// Byte-addressable data memory with lane-enabled stores, extended loads,
// access checking and a post-reset sequential clear.
module data_memory_be
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_memory,
  input  logic        read_memory,
  input  logic [1:0]  mem_size,
  input  logic        load_unsigned,
  input  logic [31:0] addr_From_Alu_Result,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        out_of_range,
  output logic        mem_busy
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_e   state_q;
  logic [AW-1:0] clr_ptr_q;
  logic [31:0]   ram_q [DEPTH];

  logic [AW-1:0] word_idx;
  logic [1:0]    byte_off;
  logic          active;
  logic          mis_raw;
  logic          oor_raw;
  logic          store_en;
  logic [3:0]    lane_en;
  logic [31:0]   wdata_rep;
  logic [31:0]   align_data;

  assign word_idx = addr_From_Alu_Result[AW+1:2];
  assign byte_off = addr_From_Alu_Result[1:0];
  assign active   = read_memory | write_memory;
  assign mem_busy = (state_q == CLEAR);

  // Raw access checks, then gated so they only report on a live access.
  always_comb begin
    oor_raw = |addr_From_Alu_Result[31:AW+2];
    mis_raw = 1'b0;
    case (mem_size)
      MEM_BYTE: mis_raw = 1'b0;
      MEM_HALF: mis_raw = byte_off[0];
      MEM_WORD: mis_raw = |byte_off;
      default:  mis_raw = 1'b1;
    endcase
    misaligned   = active & ~mem_busy & mis_raw;
    out_of_range = active & ~mem_busy & oor_raw;
  end

  // Store qualification and lane placement of right-justified store data.
  always_comb begin
    store_en = write_memory & ~mem_busy & ~mis_raw & ~oor_raw;
    lane_en  = lane_mask(mem_size, byte_off);
    case (mem_size)
      MEM_BYTE: wdata_rep = {4{write_data[7:0]}};
      MEM_HALF: wdata_rep = {2{write_data[15:0]}};
      default:  wdata_rep = write_data;
    endcase
  end

  // Clear FSM: walk every word once after reset, then stay ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else if (state_q == CLEAR) begin
      clr_ptr_q <= clr_ptr_q + 1'b1;
      if (clr_ptr_q == AW'(DEPTH - 1)) begin
        state_q <= READY;
      end
    end
  end

  // Storage array: clear writes while busy, lane-enabled stores once ready.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      ram_q[clr_ptr_q] <= 32'h0;
    end else if (store_en) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) begin
          ram_q[word_idx][8*k +: 8] <= wdata_rep[8*k +: 8];
        end
      end
    end
  end

  dmem_load_align u_align (
    .word_i     (ram_q[word_idx]),
    .offset_i   (byte_off),
    .size_i     (mem_size),
    .unsigned_i (load_unsigned),
    .data_o     (align_data)
  );

  // Loads return zero unless the access is a legal read while ready.
  always_comb begin
    read_data = 32'h0;
    if (read_memory && !mem_busy && !mis_raw && !oor_raw) begin
      read_data = align_data;
    end
  end

endmodule

// File: tb/tb_data_memory_be.sv
// Directed testbench for data_memory_be.
module tb_data_memory_be;

  logic        clk;
  logic        rst;
  logic        write_memory;
  logic        read_memory;
  logic [1:0]  mem_size;
  logic        load_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] read_data;
  logic        misaligned;
  logic        out_of_range;
  logic        mem_busy;

  int errors = 0;
  int checks = 0;

  data_memory_be #(.DEPTH(64)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .write_memory         (write_memory),
    .read_memory          (read_memory),
    .mem_size             (mem_size),
    .load_unsigned        (load_unsigned),
    .addr_From_Alu_Result (addr),
    .write_data           (wdata),
    .read_data            (read_data),
    .misaligned           (misaligned),
    .out_of_range         (out_of_range),
    .mem_busy             (mem_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    write_memory  = 1'b0;
    read_memory   = 1'b0;
    mem_size      = 2'b10;
    load_unsigned = 1'b0;
    addr          = 32'h0;
    wdata         = 32'h0;
  endtask

  // One store cycle; inputs change 1 time unit after the edge.
  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    write_memory = 1'b1;
    read_memory  = 1'b0;
    mem_size     = sz;
    addr         = a;
    wdata        = d;
    @(posedge clk);
    #1;
    idle();
  endtask

  // Set up a combinational load and let it settle.
  task automatic set_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    write_memory  = 1'b0;
    read_memory   = 1'b1;
    mem_size      = sz;
    load_unsigned = uns;
    addr          = a;
    #1;
  endtask

  // Count edges until mem_busy drops, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (mem_busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    do_store(2'b10, 32'h0000_0000, 32'hCAFE_F00D);
    do_store(2'b10, 32'h0000_00FC, 32'h1234_5678);
    @(negedge clk);
    rst = 1'b0;
    read_memory = 1'b1;
    mem_size    = 2'b11;
    addr        = 32'h0000_0101;
    #1;
    checks++;
    if (mem_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b want=1", mem_busy); end
    checks++;
    if (read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h want=00000000", read_data); end
    checks++;
    if ({misaligned, out_of_range} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b want=00", {misaligned, out_of_range}); end
    idle();
    @(negedge clk);
    rst = 1'b1;
    count_busy(n);
    checks++;
    if (n !== 64) begin errors++; $display("FAIL reset_clear_cycles got=%0d want=64", n); end
    set_load(2'b10, 1'b0, 32'h0000_0000);
    checks++;
    if (read_data !== 32'h0) begin errors++; $display("FAIL reset_word0 got=%h want=00000000", read_data); end
    set_load(2'b10, 1'b0, 32'h0000_00FC);
    checks++;
    if (read_data !== 32'h0) begin errors++; $display("FAIL reset_word63 got=%h want=00000000", read_data); end
    idle();
  endtask

  task automatic test_byte();
    do_store(2'b10, 32'h10, 32'h1122_3344);
    do_store(2'b00, 32'h11, 32'h5555_55AA);
    set_load(2'b10, 1'b0, 32'h10);
    checks++;
    if (read_data !== 32'h11AA_3344) begin errors++; $display("FAIL byte_lw got=%h want=11aa3344", read_data); end
    set_load(2'b00, 1'b0, 32'h11);
    checks++;
    if (read_data !== 32'hFFFF_FFAA) begin errors++; $display("FAIL byte_lb got=%h want=ffffffaa", read_data); end
    set_load(2'b00, 1'b1, 32'h11);
    checks++;
    if (read_data !== 32'h0000_00AA) begin errors++; $display("FAIL byte_lbu got=%h want=000000aa", read_data); end
    set_load(2'b00, 1'b0, 32'h13);
    checks++;
    if (read_data !== 32'h0000_0044) begin errors++; $display("FAIL byte_lb3 got=%h want=00000044", read_data); end
    idle();
  endtask

  task automatic test_half();
    do_store(2'b01, 32'h22, 32'hFFFF_8001);
    set_load(2'b01, 1'b0, 32'h22);
    checks++;
    if (read_data !== 32'hFFFF_8001) begin errors++; $display("FAIL half_lh got=%h want=ffff8001", read_data); end
    set_load(2'b01, 1'b1, 32'h22);
    checks++;
    if (read_data !== 32'h0000_8001) begin errors++; $display("FAIL half_lhu got=%h want=00008001", read_data); end
    set_load(2'b10, 1'b0, 32'h20);
    checks++;
    if (read_data !== 32'h0000_8001) begin errors++; $display("FAIL half_lw got=%h want=00008001", read_data); end
    do_store(2'b01, 32'h20, 32'h0000_7F02);
    set_load(2'b10, 1'b1, 32'h20);
    checks++;
    if (read_data !== 32'h7F02_8001) begin errors++; $display("FAIL half_upper got=%h want=7f028001", read_data); end
    idle();
  endtask

  task automatic test_misalign();
    write_memory = 1'b1;
    mem_size     = 2'b10;
    addr         = 32'h0D;
    wdata        = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_sw got=%b want=1", misaligned); end
    @(posedge clk);
    #1;
    mem_size = 2'b01;
    addr     = 32'h0F;
    #1;
    checks++;
    if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_sh got=%b want=1", misaligned); end
    @(posedge clk);
    #1;
    set_load(2'b10, 1'b0, 32'h0C);
    checks++;
    if (read_data !== 32'h0) begin errors++; $display("FAIL mis_unchanged got=%h want=00000000", read_data); end
    checks++;
    if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_aligned_word got=%b want=0", misaligned); end
    set_load(2'b11, 1'b0, 32'h10);
    checks++;
    if ({misaligned, read_data} !== {1'b1, 32'h0}) begin errors++; $display("FAIL mis_size11 got=%b/%h want=1/00000000", misaligned, read_data); end
    set_load(2'b01, 1'b0, 32'h11);
    checks++;
    if ({misaligned, read_data} !== {1'b1, 32'h0}) begin errors++; $display("FAIL mis_lh_odd got=%b/%h want=1/00000000", misaligned, read_data); end
    idle();
    mem_size = 2'b11;
    addr     = 32'h0000_0103;
    #1;
    checks++;
    if ({misaligned, out_of_range} !== 2'b00) begin errors++; $display("FAIL mis_inactive got=%b want=00", {misaligned, out_of_range}); end
    idle();
  endtask

  task automatic test_range();
    write_memory = 1'b1;
    mem_size     = 2'b10;
    addr         = 32'h100;
    wdata        = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({out_of_range, misaligned} !== 2'b10) begin errors++; $display("FAIL range_sw_flag got=%b want=10", {out_of_range, misaligned}); end
    @(posedge clk);
    #1;
    set_load(2'b10, 1'b0, 32'h0);
    checks++;
    if (read_data !== 32'h0) begin errors++; $display("FAIL range_word0 got=%h want=00000000", read_data); end
    set_load(2'b10, 1'b0, 32'h100);
    checks++;
    if ({out_of_range, read_data} !== {1'b1, 32'h0}) begin errors++; $display("FAIL range_lw got=%b/%h want=1/00000000", out_of_range, read_data); end
    set_load(2'b00, 1'b0, 32'h8000_0010);
    checks++;
    if (out_of_range !== 1'b1) begin errors++; $display("FAIL range_msb got=%b want=1", out_of_range); end
    idle();
  endtask

  task automatic test_back_to_back();
    do_store(2'b10, 32'h30, 32'hA5A5_0F0F);
    write_memory  = 1'b1;
    read_memory   = 1'b1;
    mem_size      = 2'b10;
    load_unsigned = 1'b0;
    addr          = 32'h30;
    wdata         = 32'h0102_0304;
    #1;
    checks++;
    if (read_data !== 32'hA5A5_0F0F) begin errors++; $display("FAIL b2b_old got=%h want=a5a50f0f", read_data); end
    @(posedge clk);
    #1;
    write_memory = 1'b0;
    #1;
    checks++;
    if (read_data !== 32'h0102_0304) begin errors++; $display("FAIL b2b_new got=%h want=01020304", read_data); end
    idle();
  endtask

  task automatic test_reset_mid_clear();
    int n;
    do_store(2'b10, 32'h0, 32'h7777_7777);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 30; i++) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (mem_busy !== 1'b1) begin errors++; $display("FAIL midclr_busy got=%b want=1", mem_busy); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    write_memory = 1'b1;
    read_memory  = 1'b1;
    mem_size     = 2'b10;
    addr         = 32'h0;
    wdata        = 32'hBAD0_BAD0;
    #1;
    checks++;
    if ({read_data, misaligned, out_of_range} !== {32'h0, 2'b00}) begin errors++; $display("FAIL midclr_busy_access got=%h/%b%b want=00000000/00", read_data, misaligned, out_of_range); end
    @(posedge clk);
    #1;
    idle();
    count_busy(n);
    checks++;
    if (n + 2 !== 64) begin errors++; $display("FAIL midclr_cycles got=%0d want=64", n + 2); end
    set_load(2'b10, 1'b0, 32'h0);
    checks++;
    if (read_data !== 32'h0) begin errors++; $display("FAIL midclr_store_blocked got=%h want=00000000", read_data); end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #12;
    rst = 1'b1;
    begin : wait_ready
      int n;
      count_busy(n);
      if (mem_busy) begin
        $display("FAIL initial_clear got=busy want=ready");
        $fatal(1, "clear never completed");
      end
    end
    test_reset();
    test_byte();
    test_half();
    test_misalign();
    test_range();
    test_back_to_back();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_be.md
# data_memory_be

Parametrised, byte-addressable data memory for the single-cycle MIPS datapath, sitting between the ALU result/register-file read port and the writeback mux. It supports byte, halfword and word stores with per-lane write enables, and sign- or zero-extended sub-word loads. It detects misaligned and out-of-range accesses. After reset it clears the array sequentially, one word per cycle, and holds `mem_busy` high until the clear completes so the control unit can stall the PC.

## Interface
- `DEPTH`, 64: number of 32-bit words; power of two, ≥ 2.
- `AW`, $clog2(DEPTH): word-index width; derived, not overridden.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted when 0).
- `write_memory` in 1: store enable.
- `read_memory` in 1: load enable.
- `mem_size` in 2: `MEM_BYTE`=00, `MEM_HALF`=01, `MEM_WORD`=10; 11 is illegal.
- `load_unsigned` in 1: 1 zero-extends sub-word loads, 0 sign-extends them.
- `addr_From_Alu_Result` in 32: byte address.
- `write_data` in 32: store data, right-justified for sub-word stores.
- `read_data` out 32: extended load result.
- `misaligned` out 1: current access is misaligned or illegal.
- `out_of_range` out 1: address is outside the array.
- `mem_busy` out 1: clear in progress; no access is accepted.

## Operation
- Addressing:
  - word index = `addr[AW+1:2]`; byte offset = `addr[1:0]`.
  - Byte lanes are big-endian: offset 0 maps to bits [31:24], offset 3 to bits [7:0].
- `out_of_range` = 1 when any of `addr[31:AW+2]` is non-zero.
- `misaligned` = 1 when any of these holds:
  - HALF with `addr[0]`=1;
  - WORD with `addr[1:0]`≠0;
  - `mem_size`=11.
- An access is active when `read_memory` or `write_memory` is 1. Both flags are combinational, valid only for an active access, and otherwise 0. Both are forced to 0 while `mem_busy` is 1.
- Store, on the clock edge, only if all of the following hold: `write_memory`=1, `mem_busy`=0, `misaligned`=0, `out_of_range`=0.
  - BYTE: writes `write_data[7:0]` into the addressed lane.
  - HALF: writes `write_data[15:0]` into lanes {0,1} or {2,3}.
  - WORD: writes all four lanes.
  - Unselected lanes are unchanged.
- Load is combinational. `read_data` = 0 in any of these cases: `read_memory`=0, `mem_busy`=1, `misaligned`=1, `out_of_range`=1. Otherwise the addressed byte, halfword or word is extended to 32 bits according to `load_unsigned`. WORD ignores `load_unsigned`.
- Clear FSM, states `CLEAR` and `READY`:
  - Reset assertion forces `CLEAR` with `clr_ptr`=0.
  - In `CLEAR`, each edge writes 0 to `ram[clr_ptr]` and increments `clr_ptr`.
  - When `clr_ptr`=DEPTH-1, the edge writes that last word and moves to `READY`.
  - `READY` is terminal until the next reset.
- `mem_busy` = 1 in `CLEAR` and 0 in `READY`.

## Timing
- Reset values: state=`CLEAR`, `clr_ptr`=0, `mem_busy`=1, `read_data`=0, `misaligned`=0, `out_of_range`=0.
- Clear takes exactly DEPTH rising edges after reset release. `mem_busy` falls after edge DEPTH, i.e. 64 cycles at the default depth.
- Reset asserted during `CLEAR` restarts the clear at `clr_ptr`=0. Reset asserted in `READY` returns the FSM to `CLEAR`.
- Store-to-load: a load in the same cycle as a store to the same word returns the old data. The new data is visible from the next cycle.
- A read and a write in the same cycle are both legal: the write commits on the edge and the read is combinational.
- Load latency is 0 cycles (combinational); store latency is 1 edge.

## Structure
- Package `dmem_pkg` holds:
  - `mem_size_e` enum (`MEM_BYTE`, `MEM_HALF`, `MEM_WORD`);
  - `dmem_state_e` enum (`CLEAR`, `READY`);
  - lane-mask constants `BE_BYTE`=4'b0001 and `BE_HALF`=4'b0011, shifted by offset.
- Sub-module `dmem_load_align` is purely combinational: it takes the word, offset, size and unsigned flag and produces the extended `read_data`.
- Store lane-enable generation and the clear FSM live in the top module.

## Test plan
- **Reset clear:** preload via stores, pulse `rst`=0, then release. `mem_busy`=1 for exactly 64 cycles, then 0. Reads of words 0 and 63 return 0x00000000.
- **Byte store/load:** SW 0x11223344 @0x10, SB 0xAA @0x11, then LW @0x10 → 0x11AA3344. LB @0x11 → 0xFFFFFFAA. LBU @0x11 → 0x000000AA.
- **Half load:** SH 0x8001 @0x22, then LH @0x22 → 0xFFFF8001, LHU @0x22 → 0x00008001, LW @0x20 → 0x00008001 given prior content 0.
- **Misalignment:** SW @0x0D and SH @0x0F → `misaligned`=1 and memory unchanged (LW @0x0C still 0). `mem_size`=11 → `misaligned`=1.
- **Range:** SW 0xDEADBEEF @0x100 with DEPTH=64 → `out_of_range`=1 and word 0 unchanged. LW @0x100 → 0.
- **Reset mid-clear:** assert `rst` at clear cycle 30. After release, `mem_busy` stays high for 64 full cycles. A store attempted while busy has no effect.
